// File: rtl/kernel_ctrl_if.sv
// -----------------------------------------------------------------------------
// kernel_ctrl_if
//   Stream bundle shared by the kernel and its frame-level controller.
//   Also holds the stream dtype encodings and the header word addresses.
//
//   dvi         data valid; only cycles with dvi=1 carry a word
//   dtypei      word type (FRAME_START, HEADER, ROW_START, pixel, ...)
//   meta_datai  header/meta word
//
//   master : stream source (drives every signal)
//   slave  : stream observer (samples every signal)
// -----------------------------------------------------------------------------
`ifndef KERNEL_CTRL_DTYPES
`define KERNEL_CTRL_DTYPES
`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_HEADER_START 4'h5
`define DTYPE_HEADER       4'h6
`define DTYPE_PIXEL_MASK   4'h8
`define Image_num_cols     6'd2
`define Image_num_rows     6'd3
`endif

interface kernel_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    dvi;
  logic [`DTYPE_WIDTH-1:0] dtypei;
  logic [DATA_WIDTH-1:0]   meta_datai;

  modport master (output dvi, output dtypei, output meta_datai);
  modport slave  (input  dvi, input  dtypei, input  meta_datai);
endinterface

// File: rtl/kernel_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_ctrl
//   Frame-level controller for the kernel row-buffer block. Watches the same
//   stream as the kernel, latches the kernel enable once per frame, captures
//   and checks the header geometry, checks row/frame lengths and reports
//   sticky errors. A geometry fault locks the kernel into bypass from the
//   next frame until clear_errors.
//
//   clk, reset     clock, synchronous active-high reset
//   strm           stream observer (dvi, dtypei, meta_datai)
//   enable_req     kernel enable request, sampled at FRAME_START
//   clear_errors   one-cycle pulse: clears err_* and bypass_lock
//   kernel_enable  enable to kernel, constant within a frame
//   busy           state != IDLE (combinational)
//   num_cols/rows  captured header geometry
//   frame_count    completed frames (wraps)
//   err_*          sticky error flags
//   bypass_lock    forces kernel_enable low from the next frame
// -----------------------------------------------------------------------------
`ifndef KERNEL_CTRL_DTYPES
`define KERNEL_CTRL_DTYPES
`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_HEADER_START 4'h5
`define DTYPE_HEADER       4'h6
`define DTYPE_PIXEL_MASK   4'h8
`define Image_num_cols     6'd2
`define Image_num_rows     6'd3
`endif

module kernel_ctrl #(
  parameter int DATA_WIDTH        = 16,
  parameter int MAX_COLS          = 1288,
  parameter int NUM_COLS_WIDTH    = 11,
  parameter int BORDER_SIZE       = 2,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  kernel_ctrl_if.slave                 strm,
  input  logic                         enable_req,
  input  logic                         clear_errors,
  output logic                         kernel_enable,
  output logic                         busy,
  output logic [DATA_WIDTH-1:0]        num_cols,
  output logic [DATA_WIDTH-1:0]        num_rows,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         err_geom,
  output logic                         err_row_len,
  output logic                         err_frame_len,
  output logic                         err_proto,
  output logic                         bypass_lock
);

  localparam logic [DATA_WIDTH-1:0] MAX_COLS_W = DATA_WIDTH'(MAX_COLS);
  localparam logic [DATA_WIDTH-1:0] BORDER_W   = DATA_WIDTH'(BORDER_SIZE);

  typedef enum logic [1:0] {IDLE, HEADER, ACTIVE} state_t;

  state_t                  state;
  logic [5:0]              header_addr;
  logic [NUM_COLS_WIDTH:0] col_cnt;
  logic [DATA_WIDTH-1:0]   row_cnt;
  logic                    in_row;

  logic                    is_pixel;
  logic                    is_frame_start;
  logic [DATA_WIDTH-1:0]   col_cnt_ext;

  assign is_pixel       = (strm.dtypei & `DTYPE_PIXEL_MASK) != '0;
  assign is_frame_start = strm.dtypei == `DTYPE_FRAME_START;
  assign col_cnt_ext    = DATA_WIDTH'(col_cnt);
  assign busy           = state != IDLE;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      header_addr   <= '0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      in_row        <= 1'b0;
      kernel_enable <= 1'b0;
      num_cols      <= '0;
      num_rows      <= '0;
      frame_count   <= '0;
      err_geom      <= 1'b0;
      err_row_len   <= 1'b0;
      err_frame_len <= 1'b0;
      err_proto     <= 1'b0;
      bypass_lock   <= 1'b0;
    end else begin
      // NOTE: with non-blocking assignments the last one in the block wins,
      // so an error set further down overrides this clear in the same cycle.
      if (clear_errors) begin
        err_geom      <= 1'b0;
        err_row_len   <= 1'b0;
        err_frame_len <= 1'b0;
        err_proto     <= 1'b0;
        bypass_lock   <= 1'b0;
      end

      if (strm.dvi) begin
        if (is_frame_start) begin
          // A FRAME_START outside IDLE means the previous frame never ended;
          // flag it and restart the frame exactly as from IDLE.
          if (state != IDLE) err_proto <= 1'b1;
          state         <= HEADER;
          kernel_enable <= enable_req & ~bypass_lock;
          row_cnt       <= '0;
        end else begin
          unique case (state)
            IDLE: begin
              if (is_pixel || strm.dtypei == `DTYPE_ROW_START ||
                  strm.dtypei == `DTYPE_ROW_END)
                err_proto <= 1'b1;
            end

            HEADER: begin
              case (strm.dtypei)
                `DTYPE_HEADER_START: header_addr <= '0;
                `DTYPE_HEADER: begin
                  if (header_addr != 6'h3F) header_addr <= header_addr + 6'd1;
                  if (header_addr == `Image_num_cols) begin
                    num_cols <= strm.meta_datai;
                    if (strm.meta_datai > MAX_COLS_W || strm.meta_datai <= BORDER_W) begin
                      err_geom    <= 1'b1;
                      bypass_lock <= 1'b1;
                    end
                  end
                  if (header_addr == `Image_num_rows) begin
                    num_rows <= strm.meta_datai;
                    if (strm.meta_datai <= BORDER_W) begin
                      err_geom    <= 1'b1;
                      bypass_lock <= 1'b1;
                    end
                  end
                end
                `DTYPE_ROW_START: begin
                  state   <= ACTIVE;
                  in_row  <= 1'b1;
                  col_cnt <= '0;
                end
                `DTYPE_FRAME_END: begin
                  state     <= IDLE;
                  err_proto <= 1'b1;
                end
                default: ;
              endcase
            end

            ACTIVE: begin
              if (is_pixel) begin
                if (!in_row)               err_proto <= 1'b1;
                else if (col_cnt != '1)    col_cnt   <= col_cnt + 1'b1;
              end else begin
                case (strm.dtypei)
                  `DTYPE_ROW_START: begin
                    col_cnt <= '0;
                    in_row  <= 1'b1;
                    if (in_row) err_proto <= 1'b1;
                  end
                  `DTYPE_ROW_END: begin
                    in_row <= 1'b0;
                    if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
                    if (col_cnt_ext != num_cols) err_row_len <= 1'b1;
                  end
                  `DTYPE_FRAME_END: begin
                    state       <= IDLE;
                    frame_count <= frame_count + 1'b1;
                    if (row_cnt != num_rows) err_frame_len <= 1'b1;
                    if (in_row)              err_proto     <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end

            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kernel_ctrl
//   Drives whole frames described by a few numbers (geometry, rows sent,
//   which row is short, enable request) and predicts the controller's outputs
//   from those numbers: enable taken at frame start, sticky errors from
//   length/geometry rules, bypass lock from geometry faults.
// -----------------------------------------------------------------------------
`ifndef KERNEL_CTRL_DTYPES
`define KERNEL_CTRL_DTYPES
`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_HEADER_START 4'h5
`define DTYPE_HEADER       4'h6
`define DTYPE_PIXEL_MASK   4'h8
`define Image_num_cols     6'd2
`define Image_num_rows     6'd3
`endif

module tb_kernel_ctrl;
  localparam int DW       = 16;
  localparam int MAX_COLS = 1288;
  localparam int BORDER   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable_req;
  logic          clear_errors;
  logic          kernel_enable, busy;
  logic [DW-1:0] num_cols, num_rows;
  logic [15:0]   frame_count;
  logic          err_geom, err_row_len, err_frame_len, err_proto, bypass_lock;

  kernel_ctrl_if #(.DATA_WIDTH(DW)) sif ();

  kernel_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .strm         (sif),
    .enable_req   (enable_req),
    .clear_errors (clear_errors),
    .kernel_enable(kernel_enable),
    .busy         (busy),
    .num_cols     (num_cols),
    .num_rows     (num_rows),
    .frame_count  (frame_count),
    .err_geom     (err_geom),
    .err_row_len  (err_row_len),
    .err_frame_len(err_frame_len),
    .err_proto    (err_proto),
    .bypass_lock  (bypass_lock)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int exp_fc, exp_cols, exp_rows;
  bit exp_geom, exp_rowe, exp_frme, exp_proto, exp_lock, exp_ke;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_geom = 0; exp_rowe = 0; exp_frme = 0; exp_proto = 0; exp_lock = 0;
  endtask

  task automatic model_reset();
    model_clear();
    exp_fc = 0; exp_cols = 0; exp_rows = 0; exp_ke = 0;
  endtask

  task automatic beat(input logic [3:0] dt, input logic [DW-1:0] d, input bit clr = 0);
    @(negedge clk);
    sif.dvi        = 1'b1;
    sif.dtypei     = dt;
    sif.meta_datai = d;
    clear_errors   = clr;
  endtask

  task automatic gap(input int n, input bit clr = 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sif.dvi      = 1'b0;
      clear_errors = clr && (i == 0);
    end
    if (clr) model_clear();
  endtask

  task automatic check_status(input string tag);
    check({tag, ".busy"},        busy,          0);
    check({tag, ".ke"},          kernel_enable, exp_ke);
    check({tag, ".num_cols"},    num_cols,      exp_cols);
    check({tag, ".num_rows"},    num_rows,      exp_rows);
    check({tag, ".frame_count"}, frame_count,   exp_fc);
    check({tag, ".err_geom"},    err_geom,      exp_geom);
    check({tag, ".err_row_len"}, err_row_len,   exp_rowe);
    check({tag, ".err_frame"},   err_frame_len, exp_frme);
    check({tag, ".err_proto"},   err_proto,     exp_proto);
    check({tag, ".bypass"},      bypass_lock,   exp_lock);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sif.dvi = 1'b0; enable_req = 1'b0; clear_errors = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_status("reset");
  endtask

  // One frame: header carries cols/rows, rows_sent rows follow; short_row (if
  // >=0) carries one pixel less; toggle_row flips enable_req mid-frame.
  task automatic send_frame(input string tag, input int cols, input int rows,
                            input int rows_sent, input int short_row, input bit en,
                            input int toggle_row, input bit end_frame, input bit clr_on_short);
    int pix, n;
    bit c;
    enable_req = en;
    beat(`DTYPE_FRAME_START, 16'(($urandom)));
    exp_ke = en & ~exp_lock;
    beat(`DTYPE_HEADER_START, 16'(($urandom)));
    check({tag, ".ke_start"}, kernel_enable, exp_ke);
    check({tag, ".busy"}, busy, 1);
    for (int a = 0; a < 5; a++)
      beat(`DTYPE_HEADER, (a == 2) ? DW'(cols) : (a == 3) ? DW'(rows) : 16'($urandom));
    exp_cols = cols;
    exp_rows = rows;
    if (cols > MAX_COLS || cols <= BORDER || rows <= BORDER) begin
      exp_geom = 1; exp_lock = 1;
    end
    pix = (cols > 16) ? 8 : cols;
    for (int r = 0; r < rows_sent; r++) begin
      if (r == toggle_row) enable_req = ~en;
      beat(`DTYPE_ROW_START, 16'($urandom));
      n = (r == short_row) ? pix - 1 : pix;
      for (int p = 0; p < n; p++)
        beat(`DTYPE_PIXEL_MASK | 4'($urandom_range(0, 7)), 16'($urandom));
      c = (r == short_row) && clr_on_short;
      beat(`DTYPE_ROW_END, 16'($urandom), c);
      if (c) model_clear();
      if (n != cols) exp_rowe = 1;
    end
    if (end_frame) begin
      beat(`DTYPE_FRAME_END, 16'($urandom));
      check({tag, ".ke_hold"}, kernel_enable, exp_ke);
      exp_fc++;
      if (rows_sent != rows) exp_frme = 1;
    end
  endtask

  initial begin
    int cols, rows, rs, sr;
    sif.dvi = 1'b0; sif.dtypei = '0; sif.meta_datai = '0;
    enable_req = 1'b0; clear_errors = 1'b0; reset = 1'b1;
    model_reset();
    do_reset();

    // Clean 8x6 frame, enable_req dropped during row 3.
    send_frame("f1", 8, 6, 6, -1, 1, 2, 1, 0);
    gap(2);
    check_status("f1");
    send_frame("f2", 8, 6, 6, -1, 0, -1, 1, 0);
    gap(2);
    check_status("f2");

    // Oversized header: current frame keeps enable, next frames bypassed,
    // clear mid-frame (coincident with a short row) re-enables the one after.
    send_frame("geom", 1300, 6, 6, -1, 1, -1, 1, 0);
    gap(2);
    check_status("geom");
    send_frame("lock", 8, 6, 6, -1, 1, -1, 1, 0);
    gap(2);
    check_status("lock");
    send_frame("clr", 8, 6, 6, 1, 1, -1, 1, 1);
    gap(2);
    check_status("clr");
    send_frame("unlock", 8, 6, 6, -1, 1, -1, 1, 0);
    gap(2);
    check_status("unlock");

    // Row length error alone, then frame length error alone.
    do_reset();
    send_frame("rowlen", 8, 6, 6, 1, 1, -1, 1, 0);
    gap(2);
    check_status("rowlen");
    do_reset();
    send_frame("frmlen", 8, 6, 5, -1, 1, -1, 1, 0);
    gap(2);
    check_status("frmlen");

    // Protocol: pixel in IDLE, then FRAME_START while ACTIVE.
    do_reset();
    beat(`DTYPE_PIXEL_MASK, 16'h1234);
    exp_proto = 1;
    gap(2);
    check_status("idle_pix");
    send_frame("restart", 8, 6, 2, -1, 1, -1, 0, 0);
    beat(`DTYPE_ROW_START, 16'h0);
    beat(`DTYPE_PIXEL_MASK, 16'h0);
    beat(`DTYPE_FRAME_START, 16'h0);
    gap(2);
    check("restart.busy", busy, 1);
    check("restart.err_proto", err_proto, 1);
    check("restart.frame_count", frame_count, exp_fc);

    // Reset in the middle of row 3, then a clean frame.
    do_reset();
    send_frame("mid", 8, 6, 2, -1, 1, -1, 0, 0);
    beat(`DTYPE_ROW_START, 16'h0);
    for (int p = 0; p < 3; p++) beat(`DTYPE_PIXEL_MASK, 16'(p));
    do_reset();
    send_frame("post", 8, 6, 6, -1, 1, -1, 1, 0);
    gap(2);
    check_status("post");

    // Randomized frames with occasional faults and clears between frames.
    do_reset();
    for (int f = 0; f < 25; f++) begin
      cols = $urandom_range(3, 12);
      rows = $urandom_range(3, 6);
      case ($urandom_range(0, 9))
        0: cols = 1300;
        1: cols = 2;
        2: rows = 1;
        default: ;
      endcase
      rs = rows;
      if ($urandom_range(0, 6) == 0 && rows > 1) rs = rows - 1;
      sr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rs - 1) : -1;
      send_frame("rnd", cols, rows, rs, sr, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, rs - 1) : -1, 1, 0);
      gap(3, $urandom_range(0, 3) == 0);
      check_status("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/kernel_ctrl.md
Name: kernel_ctrl

Overview:
- Frame-level controller for the kernel row-buffer block.
- Sits in parallel with the kernel on the same dvi/dtypei/meta_datai stream and drives the kernel's enable input.
- Applies enable changes only at frame boundaries and checks header geometry against MAX_COLS/BORDER_SIZE.
- Checks row/frame lengths against the header, reports sticky errors, and auto-bypasses the kernel after a geometry fault.

Parameters:
DATA_WIDTH, 16, width of meta_datai and captured geometry
MAX_COLS, 1288, row-buffer depth; num_cols above this is a geometry fault
NUM_COLS_WIDTH, 11, width of kernel column address
BORDER_SIZE, 2, pixels dropped per dimension by kernel (KERNEL_SIZE-1)
FRAME_COUNT_WIDTH, 16, width of frame_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dvi  in  1  stream data valid
dtypei  in  `DTYPE_WIDTH  stream data type
meta_datai  in  DATA_WIDTH  header/meta word
enable_req  in  1  register-file kernel enable request
clear_errors  in  1  one-cycle pulse; clears sticky errors and bypass lock
kernel_enable  out  1  enable to kernel, stable within a frame
busy  out  1  high when state != IDLE
num_cols  out  DATA_WIDTH  captured header column count
num_rows  out  DATA_WIDTH  captured header row count
frame_count  out  FRAME_COUNT_WIDTH  completed frames, wraps
err_geom  out  1  sticky: header geometry unsupported
err_row_len  out  1  sticky: row pixel count != num_cols
err_frame_len  out  1  sticky: row count != num_rows
err_proto  out  1  sticky: dtype sequence violation
bypass_lock  out  1  forces kernel_enable low from next frame

Behaviour:
- Reset: state=IDLE; all outputs 0; internal header_addr, col_cnt, row_cnt and in_row are 0.
- Reset mid-frame: stream is ignored until the next FRAME_START.
- Only cycles with dvi=1 are processed. dtypes are compared against the `DTYPE_* macros; a pixel is any dtype with (dtypei & `DTYPE_PIXEL_MASK) != 0.
- State IDLE:
  - FRAME_START: go to HEADER.
  - kernel_enable <= enable_req & ~bypass_lock. It is registered, so it is valid on the cycle after FRAME_START.
  - Zero row_cnt.
- State HEADER:
  - HEADER_START: header_addr <= 0.
  - HEADER: header_addr <= header_addr+1 (6 bits, saturating at 63).
  - When header_addr == `Image_num_cols on a HEADER word: capture num_cols. When header_addr == `Image_num_rows: capture num_rows.
  - Geometry check on capture:
    - num_cols > MAX_COLS, num_cols <= BORDER_SIZE, or num_rows <= BORDER_SIZE: err_geom <= 1 and bypass_lock <= 1.
    - The current frame's kernel_enable is unchanged, so the header is adjusted consistently.
  - ROW_START: go to ACTIVE, in_row <= 1, col_cnt <= 0.
  - FRAME_END: go to IDLE and set err_proto; frame_count is not incremented.
- State ACTIVE:
  - ROW_START: col_cnt <= 0, in_row <= 1. If in_row was already 1, set err_proto.
  - Pixel with in_row=1: col_cnt += 1, saturating at all-ones (NUM_COLS_WIDTH+1 bits). Pixel with in_row=0: set err_proto.
  - ROW_END: in_row <= 0; row_cnt += 1, saturating (DATA_WIDTH bits). Set err_row_len if col_cnt != num_cols. Compare against the value before the update.
  - FRAME_END: go to IDLE, frame_count += 1. Set err_frame_len if row_cnt != num_rows (includes a ROW_END on the same cycle, which is not possible). Set err_proto if in_row=1.
  - FRAME_START (no FRAME_END seen): set err_proto and restart as if in IDLE, i.e. go to HEADER and resample kernel_enable. frame_count is not incremented.
- Pixels, ROW_START or ROW_END in IDLE: set err_proto; state is unchanged.
- enable_req changes mid-frame have no effect until the next FRAME_START.
- clear_errors clears all err_* and bypass_lock. If an error is set in the same cycle, the set wins.
- clear_errors does not change kernel_enable mid-frame.
- busy is combinational from state.
- Latency: every output is registered with 1-cycle latency from the triggering dvi cycle, except busy.

Test Plan:
- enable_req=1, 8x6 frame (header num_cols=8, num_rows=6, 6 rows of 8 pixels) -> kernel_enable=1 from the cycle after FRAME_START; no errors; frame_count=1; busy low after FRAME_END.
- Toggle enable_req 1->0 during row 3 of frame 1 -> kernel_enable stays 1 until frame 2 FRAME_START+1, then 0.
- Header num_cols=1300 with enable_req=1 -> err_geom=1, bypass_lock=1, current frame kernel_enable=1, next frame kernel_enable=0; clear_errors during frame 3 -> kernel_enable=1 at frame 4.
- Row 2 carries 7 pixels with num_cols=8 -> err_row_len=1 only. Frame ends after 5 rows with num_rows=6 -> err_frame_len=1.
- Pixel before any FRAME_START, then FRAME_START mid-ACTIVE -> err_proto=1, state HEADER, frame_count unchanged.
- Assert reset mid-row 3, release, send a full 8x6 frame -> all outputs 0 after reset; clean frame gives frame_count=1 and no errors. clear_errors coincident with a row-length error leaves err_row_len=1.
